// File: rtl/mbus_video_writer.sv
// mbus_video_writer: packs RGB565 pixels into 128-bit beats, buffers them in a
// small FIFO and writes 16-beat bursts into a ping-pong DDR frame buffer.
module mbus_video_writer #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 16,
    parameter int                         BURST_LENGTH    = 8,
    parameter int                         BURST_BEATS     = 16,
    parameter int                         DEVICE_NUM      = 4,
    parameter int                         DEVICE_ID       = 0,
    parameter int                         FRAME_PIXELS    = 2073600,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE0     = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE1     = 28'h0400000,
    parameter int                         FIFO_DEPTH      = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [23:0]                          i_pix_data,
    input  logic                                 i_pix_valid,
    input  logic                                 i_pix_sof,
    output logic                                 o_mbus_wrq,
    output logic [CTRL_ADDR_WIDTH-1:0]           o_mbus_waddr,
    output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0] o_mbus_wdata,
    output logic                                 o_mbus_wready,
    input  logic                                 i_mbus_wdata_rq,
    input  logic                                 i_mbus_wbusy,
    input  logic [DEVICE_NUM-1:0]                i_mbus_wsel,
    output logic                                 o_done_buf,
    output logic                                 o_frame_done,
    output logic                                 o_overflow,
    output logic                                 o_frame_err
);

    localparam int BEAT_W = MEM_DQ_WIDTH * BURST_LENGTH;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int BW     = $clog2(BURST_BEATS);
    localparam int SW     = $clog2(BURST_LENGTH);

    localparam logic [PW:0]                CNT_BURST   = (PW+1)'(BURST_BEATS);
    localparam logic [PW:0]                CNT_FULL    = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]              LAST_BEAT   = BW'(BURST_BEATS - 1);
    localparam logic [SW-1:0]              LAST_SLOT   = SW'(BURST_LENGTH - 1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] BURST_WORDS = CTRL_ADDR_WIDTH'(BURST_BEATS * BURST_LENGTH);
    localparam logic [CTRL_ADDR_WIDTH-1:0] FRAME_WORDS = CTRL_ADDR_WIDTH'(FRAME_PIXELS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_PAD, S_WAIT} state_t;

    state_t                       state_q, state_d;
    logic                         wrq_q, wrq_d;
    logic [CTRL_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [CTRL_ADDR_WIDTH-1:0]   offset_q, offset_d;
    logic                         buf_q, buf_d;
    logic                         done_buf_q, done_buf_d;
    logic                         frame_done_q, frame_done_d;
    logic                         overflow_q, overflow_d;
    logic                         frame_err_q, frame_err_d;
    logic                         stale_q, stale_d;
    logic                         rq_prev_q, rq_prev_d;
    logic [BW-1:0]                beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]                slot_q, slot_d;
    logic [BEAT_W-1:0]            pack_q, pack_d;
    logic [PW-1:0]                wptr_q, wptr_d;
    logic [PW-1:0]                rptr_q, rptr_d;
    logic [PW:0]                  cnt_q, cnt_d;
    logic [BEAT_W-1:0]            mem_q [FIFO_DEPTH];

    logic        sof;
    logic        grant;
    logic        take;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic [15:0] pix565;
    logic        unused_ok;

    assign sof        = i_pix_valid & i_pix_sof;
    assign grant      = i_mbus_wsel[DEVICE_ID];
    assign take       = grant & i_mbus_wdata_rq;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign pix565     = {i_pix_data[23:19], i_pix_data[15:10], i_pix_data[7:3]};
    assign unused_ok  = ^{i_mbus_wsel, i_pix_data[18:16], i_pix_data[9:8], i_pix_data[2:0]};

    // next-state for packer, FIFO pointers, burst FSM and address bookkeeping
    always_comb begin
        state_d      = state_q;
        wrq_d        = wrq_q;
        offset_d     = offset_q;
        buf_d        = buf_q;
        done_buf_d   = done_buf_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        frame_err_d  = frame_err_q;
        stale_d      = stale_q;
        rq_prev_d    = i_mbus_wdata_rq;
        beat_cnt_d   = beat_cnt_q;
        slot_d       = slot_q;
        pack_d       = pack_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (i_pix_valid) begin
            if (sof) begin
                pack_d        = '0;
                pack_d[15:0]  = pix565;
                slot_d        = SW'(1);
            end else begin
                pack_d[{slot_q, 4'b0000} +: 16] = pix565;
                slot_d = slot_q + SW'(1);
                push   = (slot_q == LAST_SLOT);
            end
        end
        push_ok = push & ~fifo_full;
        if (push & fifo_full) overflow_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (cnt_q >= CNT_BURST) begin
                    state_d = S_REQ;
                    wrq_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (grant & i_mbus_wdata_rq & ~rq_prev_q) begin
                    state_d    = S_XFER;
                    wrq_d      = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            S_XFER: begin
                if (take & ~fifo_empty) begin
                    pop        = 1'b1;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = S_WAIT;
                end
            end
            S_PAD: begin
                if (take) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_mbus_wbusy) begin
                    state_d = S_IDLE;
                    stale_d = 1'b0;
                    if (!stale_q) begin
                        if (offset_q + BURST_WORDS == FRAME_WORDS) begin
                            offset_d     = '0;
                            frame_done_d = 1'b1;
                            done_buf_d   = buf_q;
                        end else begin
                            offset_d = offset_q + BURST_WORDS;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);
        cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);

        if (sof) begin
            if (slot_q != '0 || cnt_q > (PW+1)'(pop) ||
                (state_q == S_XFER && state_d == S_XFER))
                frame_err_d = 1'b1;
            wptr_d   = '0;
            rptr_d   = '0;
            cnt_d    = '0;
            buf_d    = ~buf_q;
            offset_d = '0;
            if (state_q == S_REQ) begin
                state_d = S_IDLE;
                wrq_d   = 1'b0;
            end
            if (state_q == S_XFER && state_d == S_XFER) state_d = S_PAD;
            // a burst still in flight belongs to the abandoned frame
            stale_d = (state_d == S_XFER) || (state_d == S_PAD) || (state_d == S_WAIT);
        end

        waddr_d = (buf_d ? FRAME_BASE1 : FRAME_BASE0) + offset_d;
    end

    // state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            wrq_q        <= 1'b0;
            waddr_q      <= FRAME_BASE0;
            offset_q     <= '0;
            buf_q        <= 1'b0;
            done_buf_q   <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            stale_q      <= 1'b0;
            rq_prev_q    <= 1'b0;
            beat_cnt_q   <= '0;
            slot_q       <= '0;
            pack_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            wrq_q        <= wrq_d;
            waddr_q      <= waddr_d;
            offset_q     <= offset_d;
            buf_q        <= buf_d;
            done_buf_q   <= done_buf_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
            stale_q      <= stale_d;
            rq_prev_q    <= rq_prev_d;
            beat_cnt_q   <= beat_cnt_d;
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // beat storage; completed beats land here unless the FIFO is full
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wptr_q] <= pack_d;
    end

    assign o_mbus_wrq    = wrq_q;
    assign o_mbus_waddr  = waddr_q;
    assign o_mbus_wdata  = (state_q == S_XFER) ? mem_q[rptr_q] : '0;
    assign o_mbus_wready = (state_q == S_XFER) ? ~fifo_empty : (state_q == S_PAD);
    assign o_done_buf    = done_buf_q;
    assign o_frame_done  = frame_done_q;
    assign o_overflow    = overflow_q;
    assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_mbus_video_writer.sv
// Bench for mbus_video_writer: directed sequence with random pixel data,
// checked against a queue-based model of packing, FIFO and addressing.
module tb_mbus_video_writer;

    localparam int          FP    = 256;
    localparam logic [27:0] BASE0 = 28'h0000000;
    localparam logic [27:0] BASE1 = 28'h0400000;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [23:0]  i_pix_data;
    logic         i_pix_valid;
    logic         i_pix_sof;
    logic         o_mbus_wrq;
    logic [27:0]  o_mbus_waddr;
    logic [127:0] o_mbus_wdata;
    logic         o_mbus_wready;
    logic         i_mbus_wdata_rq;
    logic         i_mbus_wbusy;
    logic [3:0]   i_mbus_wsel;
    logic         o_done_buf;
    logic         o_frame_done;
    logic         o_overflow;
    logic         o_frame_err;

    mbus_video_writer #(.FRAME_PIXELS(FP)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_pix_data     (i_pix_data),
        .i_pix_valid    (i_pix_valid),
        .i_pix_sof      (i_pix_sof),
        .o_mbus_wrq     (o_mbus_wrq),
        .o_mbus_waddr   (o_mbus_waddr),
        .o_mbus_wdata   (o_mbus_wdata),
        .o_mbus_wready  (o_mbus_wready),
        .i_mbus_wdata_rq(i_mbus_wdata_rq),
        .i_mbus_wbusy   (i_mbus_wbusy),
        .i_mbus_wsel    (i_mbus_wsel),
        .o_done_buf     (o_done_buf),
        .o_frame_done   (o_frame_done),
        .o_overflow     (o_overflow),
        .o_frame_err    (o_frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fd_seen  = 0;

    logic [15:0]  pend [$];
    logic [127:0] exp_q [$];
    bit           m_buf      = 1'b0;
    bit           m_err      = 1'b0;
    bit           m_ovf      = 1'b0;
    bit           m_done_buf = 1'b1;
    int           m_idx      = 0;
    int           m_done_cnt = 0;
    logic [127:0] last_beat;

    always @(posedge clk) if (o_frame_done === 1'b1) fd_seen <= fd_seen + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]) / 8;
        g = int'(p[15:8]) / 4;
        b = int'(p[7:0]) / 8;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic logic [27:0] m_addr();
        return (m_buf ? BASE1 : BASE0) + 28'(128 * m_idx);
    endfunction

    task automatic pix(input logic [23:0] px, input bit sof);
        logic [127:0] beat;
        if (sof) begin
            if (pend.size() != 0 || exp_q.size() != 0) m_err = 1'b1;
            pend.delete();
            exp_q.delete();
            m_buf = ~m_buf;
            m_idx = 0;
        end
        pend.push_back(to565(px));
        if (pend.size() == 8) begin
            beat = '0;
            for (int k = 0; k < 8; k++) beat = beat | (128'(pend[k]) << (16 * k));
            if (exp_q.size() >= 32) m_ovf = 1'b1;
            else exp_q.push_back(beat);
            pend.delete();
        end
        i_pix_data  = px;
        i_pix_valid = 1'b1;
        i_pix_sof   = sof;
        step();
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'b0;
    endtask

    task automatic feed(input int n, input bit first_sof, input bit konst, input logic [23:0] kv);
        for (int i = 0; i < n; i++) pix(konst ? kv : 24'($urandom()), first_sof && (i == 0));
    endtask

    task automatic serve(input string tag, input int ntake);
        int t;
        int n;
        logic [127:0] e;
        t = 0;
        while (o_mbus_wrq !== 1'b1 && t < 200) begin step(); t++; end
        chk({tag, "_wrq"}, 128'(o_mbus_wrq), 128'(1));
        chk({tag, "_addr"}, 128'(o_mbus_waddr), 128'(m_addr()));
        i_mbus_wsel     = 4'b0001;
        i_mbus_wdata_rq = 1'b1;
        step();
        chk({tag, "_wrq_drop"}, 128'(o_mbus_wrq), 128'(0));
        n = 0;
        t = 0;
        while (n < ntake && t < 64) begin
            if (o_mbus_wready === 1'b1) begin
                e = '0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                last_beat = o_mbus_wdata;
                chk($sformatf("%s_beat%0d", tag, n), o_mbus_wdata, e);
                n++;
            end
            step();
            t++;
        end
        i_mbus_wdata_rq = 1'b0;
        chk({tag, "_nbeats"}, 128'(n), 128'(ntake));
        if (ntake == 16) begin
            m_idx++;
            if (m_idx == FP / 128) begin
                m_idx      = 0;
                m_done_buf = m_buf;
                m_done_cnt++;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wrq"}, 128'(o_mbus_wrq), 128'(0));
        chk({tag, "_waddr"}, 128'(o_mbus_waddr), 128'(BASE0));
        chk({tag, "_wdata"}, o_mbus_wdata, 128'(0));
        chk({tag, "_wready"}, 128'(o_mbus_wready), 128'(0));
        chk({tag, "_done_buf"}, 128'(o_done_buf), 128'(1));
        chk({tag, "_frame_done"}, 128'(o_frame_done), 128'(0));
        chk({tag, "_overflow"}, 128'(o_overflow), 128'(0));
        chk({tag, "_frame_err"}, 128'(o_frame_err), 128'(0));
    endtask

    task automatic settle_and_check_frames(input string tag);
        for (int i = 0; i < 4; i++) step();
        chk({tag, "_frame_done_cnt"}, 128'(fd_seen), 128'(m_done_cnt));
        chk({tag, "_done_buf"}, 128'(o_done_buf), 128'(m_done_buf));
    endtask

    initial begin
        int npad;
        int t;
        bit busy_seen;

        i_rst           = 1'b1;
        i_pix_data      = '0;
        i_pix_valid     = 1'b0;
        i_pix_sof       = 1'b0;
        i_mbus_wdata_rq = 1'b0;
        i_mbus_wbusy    = 1'b0;
        i_mbus_wsel     = 4'b0000;
        repeat (3) step();
        i_rst = 1'b0;
        step();
        check_reset("reset");

        // one burst of a constant pixel, request timing and lane packing
        feed(127, 1'b0, 1'b1, 24'hFF8040);
        pix(24'hFF8040, 1'b0);
        chk("wrq_not_yet", 128'(o_mbus_wrq), 128'(0));
        step();
        chk("wrq_rises", 128'(o_mbus_wrq), 128'(1));
        serve("b0", 16);
        chk("rgb565_ff8040", last_beat, {8{16'hFC08}});

        // second burst completes the 256-pixel frame in buffer 0
        feed(128, 1'b0, 1'b0, 24'h0);
        serve("b1", 16);
        settle_and_check_frames("frame0");

        // clean sof switches to buffer 1; fill the FIFO to exactly full
        feed(256, 1'b1, 1'b0, 24'h0);
        chk("no_ovf_at_full", 128'(o_overflow), 128'(m_ovf));
        chk("no_err_clean_sof", 128'(o_frame_err), 128'(m_err));
        serve("f1b0", 16);
        serve("f1b1", 16);
        settle_and_check_frames("frame1");

        // sof arriving after 5 beats of a burst forces 11 padding beats
        feed(128, 1'b0, 1'b0, 24'h0);
        serve("mid", 5);
        pix(24'($urandom()), 1'b1);
        i_mbus_wdata_rq = 1'b1;
        npad = 0;
        t    = 0;
        while (o_mbus_wready === 1'b1 && t < 30) begin
            chk($sformatf("pad%0d", npad), o_mbus_wdata, 128'(0));
            npad++;
            step();
            t++;
        end
        i_mbus_wdata_rq = 1'b0;
        chk("pad_count", 128'(npad), 128'(11));
        chk("frame_err_set", 128'(o_frame_err), 128'(m_err));
        feed(127, 1'b0, 1'b0, 24'h0);
        serve("after_sof", 16);
        settle_and_check_frames("after_sof");

        // 40 beats with no data requests: 8 beats must be lost
        feed(320, 1'b0, 1'b0, 24'h0);
        chk("overflow_set", 128'(o_overflow), 128'(m_ovf));
        serve("ovf0", 16);
        serve("ovf1", 16);
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_mbus_wrq !== 1'b0) busy_seen = 1'b1;
            step();
        end
        chk("no_extra_request", 128'(busy_seen), 128'(0));
        settle_and_check_frames("ovf");

        // reset in the middle of a transfer
        feed(128, 1'b0, 1'b0, 24'h0);
        serve("pre_rst", 3);
        i_mbus_wdata_rq = 1'b1;
        i_rst           = 1'b1;
        step();
        check_reset("mid_rst");
        i_rst = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_mbus_wready !== 1'b0 || o_mbus_wrq !== 1'b0) busy_seen = 1'b1;
            step();
        end
        i_mbus_wdata_rq = 1'b0;
        chk("no_pop_after_rst", 128'(busy_seen), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
